// File: rtl/fft_pkg.sv
// Shared types and address arithmetic for the in-place radix-2 DIT FFT sequencer.
// The butterfly address function is width-agnostic; callers keep the low bits they need.
package fft_pkg;

    localparam int DEF_N_LOG2       = 5;
    localparam int DEF_BFLY_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tw;
    } bfly_addr_t;

    // Butterfly (s,k) pairs A with A+span; the twiddle step shrinks as the span grows.
    function automatic bfly_addr_t bfly_addr(
        input logic [31:0] n_log2,
        input logic [31:0] stage,
        input logic [31:0] k
    );
        bfly_addr_t  r;
        logic [31:0] span;
        logic [31:0] pos;
        logic [31:0] grp;
        span = 32'd1 << stage;
        pos  = k & (span - 32'd1);
        grp  = k >> stage;
        r.a  = (grp << (stage + 32'd1)) | pos;
        r.b  = r.a + span;
        r.tw = pos << (n_log2 - 32'd1 - stage);
        return r;
    endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// Delay line turning the read-side {valid, A, B} into the write-back port BFLY_LATENCY cycles later.
// Each stage only captures addresses alongside a valid flag, so the outputs hold between writes.
module fft_wr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH     = DEF_BFLY_LATENCY,
    parameter int ADDR_SIZE = DEF_N_LOG2
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 rd_valid,
    input  logic [ADDR_SIZE-1:0] rd_addr_a,
    input  logic [ADDR_SIZE-1:0] rd_addr_b,
    output logic                 wr_valid,
    output logic [ADDR_SIZE-1:0] wr_addr_a,
    output logic [ADDR_SIZE-1:0] wr_addr_b
);

    logic [DEPTH-1:0]     vld_r;
    logic [ADDR_SIZE-1:0] a_r [DEPTH];
    logic [ADDR_SIZE-1:0] b_r [DEPTH];

    logic [DEPTH-1:0]     src_vld_s;
    logic [ADDR_SIZE-1:0] src_a_s [DEPTH];
    logic [ADDR_SIZE-1:0] src_b_s [DEPTH];

    // Source of each stage: the read port for stage 0, the previous stage otherwise.
    always_comb begin
        src_vld_s[0] = rd_valid;
        src_a_s[0]   = rd_addr_a;
        src_b_s[0]   = rd_addr_b;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld_s[i] = vld_r[i-1];
            src_a_s[i]   = a_r[i-1];
            src_b_s[i]   = b_r[i-1];
        end
    end

    // Shift register; reset flushes pending writes so none leak out afterwards.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
            end
        end else begin
            vld_r <= src_vld_s;
            for (int i = 0; i < DEPTH; i++) begin
                if (src_vld_s[i]) begin
                    a_r[i] <= src_a_s[i];
                    b_r[i] <= src_b_s[i];
                end
            end
        end
    end

    assign wr_valid  = vld_r[DEPTH-1];
    assign wr_addr_a = a_r[DEPTH-1];
    assign wr_addr_b = b_r[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks every stage/butterfly of an N-point in-place FFT, one butterfly per cycle,
// with a BFLY_LATENCY drain gap per stage so write-back never overlaps the next stage's reads.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N_LOG2         = DEF_N_LOG2,
    parameter int ADDR_SIZE      = N_LOG2,
    parameter int TWID_ADDR_SIZE = N_LOG2 - 1,
    parameter int BFLY_LATENCY   = DEF_BFLY_LATENCY
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rden,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_A,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_B,
    output logic [TWID_ADDR_SIZE-1:0]  o_rdaddr_tw,
    output logic                       o_wren,
    output logic [ADDR_SIZE-1:0]       o_wraddr_A,
    output logic [ADDR_SIZE-1:0]       o_wraddr_B,
    output logic [$clog2(N_LOG2)-1:0]  o_stage
);

    localparam int K_W     = N_LOG2 - 1;
    localparam int STAGE_W = $clog2(N_LOG2);
    localparam int DRAIN_W = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

    localparam logic [K_W-1:0]     K_LAST     = {K_W{1'b1}};
    localparam logic [STAGE_W-1:0] S_LAST     = STAGE_W'(N_LOG2 - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(BFLY_LATENCY - 1);

    fft_state_t           state_r, state_s;
    logic [STAGE_W-1:0]   s_r, s_s;
    logic [K_W-1:0]       k_r, k_s;
    logic [DRAIN_W-1:0]   drain_r, drain_s;

    logic                      busy_r;
    logic                      done_r;
    logic                      rden_r;
    logic [ADDR_SIZE-1:0]      rdaddr_a_r;
    logic [ADDR_SIZE-1:0]      rdaddr_b_r;
    logic [TWID_ADDR_SIZE-1:0] rdaddr_tw_r;
    logic [STAGE_W-1:0]        stage_r;

    bfly_addr_t bfly_s;
    logic       unused_s;

    // Outputs are registered from the next state, so addresses target the upcoming cycle.
    assign bfly_s   = bfly_addr(32'(N_LOG2), 32'(s_s), 32'(k_s));
    assign unused_s = ^bfly_s;

    // Next-state logic: stage/butterfly counters and per-stage drain counter.
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        k_s     = k_r;
        drain_s = drain_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s = READ;
                    s_s     = '0;
                    k_s     = '0;
                    drain_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (k_r == K_LAST) begin
                    state_s = DRAIN;
                    drain_s = '0;
                end else begin
                    k_s = k_r + K_W'(1);
                end
            end
            DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    if (s_r == S_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                        s_s     = s_r + STAGE_W'(1);
                        k_s     = '0;
                    end
                end else begin
                    drain_s = drain_r + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; read addresses are only reloaded on read cycles.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r     <= IDLE;
            s_r         <= '0;
            k_r         <= '0;
            drain_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rden_r      <= 1'b0;
            rdaddr_a_r  <= '0;
            rdaddr_b_r  <= '0;
            rdaddr_tw_r <= '0;
            stage_r     <= '0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            k_r     <= k_s;
            drain_r <= drain_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            rden_r  <= (state_s == READ);
            stage_r <= s_s;
            if (state_s == READ) begin
                rdaddr_a_r  <= bfly_s.a[ADDR_SIZE-1:0];
                rdaddr_b_r  <= bfly_s.b[ADDR_SIZE-1:0];
                rdaddr_tw_r <= bfly_s.tw[TWID_ADDR_SIZE-1:0];
            end
        end
    end

    fft_wr_delay #(
        .DEPTH     (BFLY_LATENCY),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_wr_delay (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .rd_valid  (rden_r),
        .rd_addr_a (rdaddr_a_r),
        .rd_addr_b (rdaddr_b_r),
        .wr_valid  (o_wren),
        .wr_addr_a (o_wraddr_A),
        .wr_addr_b (o_wraddr_B)
    );

    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_rden      = rden_r;
    assign o_rdaddr_A  = rdaddr_a_r;
    assign o_rdaddr_B  = rdaddr_b_r;
    assign o_rdaddr_tw = rdaddr_tw_r;
    assign o_stage     = stage_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench: directed vectors, a schedule model derived from cycle arithmetic,
// random start noise while busy, back-to-back restart and mid-stage reset.
module tb_fft_stage_sequencer;

    localparam int N_LOG2   = 5;
    localparam int LAT      = 3;
    localparam int HALF     = 16;
    localparam int PERIOD   = HALF + LAT;
    localparam int DONE_CYC = 1 + N_LOG2 * PERIOD;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy, done, rden, wren;
    logic [4:0] ra, rb, wa, wb;
    logic [3:0] rt;
    logic [2:0] stage;

    int checks = 0;
    int errors = 0;
    int m_ra, m_rb, m_rt, m_wa, m_wb;

    typedef struct {
        int   cyc;
        logic rden;
        int   a, b, tw;
        logic wren;
        int   wa, wb;
        logic done, busy;
    } vec_t;
    vec_t tbl [10];

    fft_stage_sequencer dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_rden      (rden),
        .o_rdaddr_A  (ra),
        .o_rdaddr_B  (rb),
        .o_rdaddr_tw (rt),
        .o_wren      (wren),
        .o_wraddr_A  (wa),
        .o_wraddr_B  (wb),
        .o_stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Butterfly addresses written with division/modulo rather than masks and shifts.
    function automatic void ref_addr(input int s, input int k, output int a, output int b, output int tw);
        int span;
        span = 2 ** s;
        a    = (k / span) * (2 * span) + (k % span);
        b    = a + span;
        tw   = (k % span) * (2 ** (N_LOG2 - 1 - s));
    endfunction

    // Cycle t (t=1 is the first cycle after start) is a read of butterfly (s,k)?
    function automatic bit ref_read(input int t, output int s, output int k);
        s = 0;
        k = 0;
        if (t < 1) return 1'b0;
        s = (t - 1) / PERIOD;
        k = (t - 1) % PERIOD;
        return (s < N_LOG2) && (k < HALF);
    endfunction

    task automatic check_cycle(input int t);
        int  s, k, ws, wk, a, b, tw;
        bit  rd, wr;
        rd = ref_read(t, s, k);
        wr = ref_read(t - LAT, ws, wk);
        if (rd) begin
            ref_addr(s, k, a, b, tw);
            m_ra = a; m_rb = b; m_rt = tw;
        end
        if (wr) begin
            ref_addr(ws, wk, a, b, tw);
            m_wa = a; m_wb = b;
        end
        chk("rden", rden, rd);
        chk("rdaddr_A", ra, m_ra);
        chk("rdaddr_B", rb, m_rb);
        chk("rdaddr_tw", rt, m_rt);
        chk("wren", wren, wr);
        chk("wraddr_A", wa, m_wa);
        chk("wraddr_B", wb, m_wb);
        chk("done", done, (t == DONE_CYC));
        chk("busy", busy, (t >= 1 && t <= DONE_CYC));
        if (rd) chk("stage", stage, s);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_rden"}, rden, 1'b0);
        chk({nm, "_wren"}, wren, 1'b0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
        chk({nm, "_rdaddr_A"}, ra, m_ra);
        chk({nm, "_wraddr_B"}, wb, m_wb);
    endtask

    task automatic run(input bit noise, input bit use_table);
        int nr, nw, nd, overlap;
        int wq [$];
        int wst;
        nr = 0; nw = 0; nd = 0; overlap = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= DONE_CYC + 1; t++) begin
            check_cycle(t);
            if (use_table) begin
                for (int i = 0; i < 10; i++) begin
                    if (tbl[i].cyc == t) begin
                        chk("tbl_rden", rden, tbl[i].rden);
                        chk("tbl_rdaddr_A", ra, tbl[i].a);
                        chk("tbl_rdaddr_B", rb, tbl[i].b);
                        chk("tbl_rdaddr_tw", rt, tbl[i].tw);
                        chk("tbl_wren", wren, tbl[i].wren);
                        chk("tbl_wraddr_A", wa, tbl[i].wa);
                        chk("tbl_wraddr_B", wb, tbl[i].wb);
                        chk("tbl_done", done, tbl[i].done);
                        chk("tbl_busy", busy, tbl[i].busy);
                    end
                end
            end
            if (rden) nr++;
            if (done) nd++;
            if (wren) begin
                nw++;
                wst = (wq.size() > 0) ? wq.pop_front() : -1;
                if (rden && wst != int'(stage)) overlap++;
            end
            if (rden) wq.push_back(int'(stage));
            if (t <= DONE_CYC) begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end else begin
                start = 1'b0;
            end
        end
        chk("rden_count", nr, N_LOG2 * HALF);
        chk("wren_count", nw, N_LOG2 * HALF);
        chk("done_count", nd, 1);
        chk("wr_rd_overlap", overlap, 0);
    endtask

    initial begin
        tbl[0] = '{1,  1'b1, 0,  1,  0,  1'b0, 0,  0,  1'b0, 1'b1};
        tbl[1] = '{2,  1'b1, 2,  3,  0,  1'b0, 0,  0,  1'b0, 1'b1};
        tbl[2] = '{3,  1'b1, 4,  5,  0,  1'b0, 0,  0,  1'b0, 1'b1};
        tbl[3] = '{4,  1'b1, 6,  7,  0,  1'b1, 0,  1,  1'b0, 1'b1};
        tbl[4] = '{17, 1'b0, 30, 31, 0,  1'b1, 26, 27, 1'b0, 1'b1};
        tbl[5] = '{20, 1'b1, 0,  2,  0,  1'b0, 30, 31, 1'b0, 1'b1};
        tbl[6] = '{21, 1'b1, 1,  3,  8,  1'b0, 30, 31, 1'b0, 1'b1};
        tbl[7] = '{92, 1'b1, 15, 31, 15, 1'b1, 12, 28, 1'b0, 1'b1};
        tbl[8] = '{96, 1'b0, 15, 31, 15, 1'b0, 15, 31, 1'b1, 1'b1};
        tbl[9] = '{97, 1'b0, 15, 31, 15, 1'b0, 15, 31, 1'b0, 1'b0};

        m_ra = 0; m_rb = 0; m_rt = 0; m_wa = 0; m_wb = 0;
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle: every output stays zero.
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle_all_zero",
                {busy, done, rden, ra, rb, rt, wren, wa, wb, stage}, 32'd0);
            tick();
        end

        // Directed transform straight out of reset, vectors plus model.
        run(1'b0, 1'b1);

        // Back-to-back restart in cycle 97, then random gaps with start noise while busy.
        run(1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            int gap;
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                tick();
                check_idle("gap");
            end
            run(1'b1, 1'b0);
        end

        // Mid-stage reset in cycle 40.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 40; t++) begin
            check_cycle(t);
            tick();
        end
        check_cycle(40);
        rst = 1'b1;
        #1;
        chk("midreset_all_zero",
            {busy, done, rden, ra, rb, rt, wren, wa, wb, stage}, 32'd0);
        m_ra = 0; m_rb = 0; m_rt = 0; m_wa = 0; m_wb = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("post_reset");
        end

        // FSM must have come back in IDLE and run a clean transform.
        run(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
